// File: rtl/fpu_pkg.sv
// Shared FPU datapath constants and the normalize-result record handed to the rounding stage.
package fpu_pkg;

    localparam int FPU_MANT_W   = 55;
    localparam int FPU_MANT_LOG = 6;
    localparam int FPU_EXP_W    = 11;

    typedef struct packed {
        logic [FPU_MANT_W-1:0] mant;
        logic [FPU_EXP_W-1:0]  exp;
        logic                  zero;
        logic                  denorm;
    } norm_result_t;

endpackage

// File: rtl/fpu_lshift_stage.sv
// Combinational left shift by a slice of the shift amount, scaled by 2**STEP_LOG.
module fpu_lshift_stage #(
    parameter int WIDTH    = 55,
    parameter int STEP_LOG = 0,
    parameter int AMT_W    = 3
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] data_out
);

    logic [AMT_W+STEP_LOG-1:0] bits;

    assign bits     = (AMT_W+STEP_LOG)'(amt) << STEP_LOG;
    assign data_out = data_in << bits;

endmodule

// File: rtl/fpu_norm_shifter.sv
// Normalizing left shifter: moves the leading one to the MSB and adjusts the exponent,
// clamping to a denormal when the exponent cannot absorb the full shift.
module fpu_norm_shifter
    import fpu_pkg::*;
#(
    parameter int WIDTH     = FPU_MANT_W,
    parameter int WIDTH_LOG = FPU_MANT_LOG,
    parameter int EXP_W     = FPU_EXP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mant,
    input  logic [WIDTH_LOG-1:0] in_msb,
    input  logic [EXP_W-1:0]     in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mant,
    output logic [EXP_W-1:0]     out_exp,
    output logic                 out_zero,
    output logic                 out_denorm
);

    // Out-of-range msb indices are treated as the top bit (no shift).
    function automatic logic [WIDTH_LOG-1:0] limit_msb(input logic [WIDTH_LOG-1:0] msb);
        return (int'(msb) >= WIDTH) ? WIDTH_LOG'(WIDTH - 1) : msb;
    endfunction

    logic                 en1, en2;
    logic                 vld_p1, vld_p2;
    logic                 zero_c, denorm_c;
    logic [WIDTH_LOG-1:0] raw_c, shamt_c;
    logic [EXP_W-1:0]     exp_c;
    logic [EXP_W:0]       exp_ext, raw_ext;
    logic [WIDTH-1:0]     mant_hi_c, mant_lo_c;

    logic [WIDTH-1:0]     mant_p1;
    logic [2:0]           shamt_lo_p1;
    logic [EXP_W-1:0]     exp_p1;
    logic                 zero_p1, denorm_p1;

    assign en2       = ~vld_p2 | out_ready;
    assign en1       = ~vld_p1 | en2;
    assign in_ready  = en1;
    assign out_valid = vld_p2;

    assign zero_c  = ~|in_mant;
    assign raw_c   = WIDTH_LOG'(WIDTH - 1) - limit_msb(in_msb);
    assign exp_ext = {1'b0, in_exp};
    assign raw_ext = (EXP_W+1)'(raw_c);

    // The shift never exceeds raw, so no set bit is lost off the top.
    always_comb begin
        shamt_c  = '0;
        exp_c    = '0;
        denorm_c = 1'b0;
        if (!zero_c) begin
            if (exp_ext > raw_ext) begin
                shamt_c = raw_c;
                exp_c   = EXP_W'(exp_ext - raw_ext);
            end else begin
                shamt_c  = (in_exp == '0) ? '0 : WIDTH_LOG'(exp_ext - 1'b1);
                denorm_c = 1'b1;
            end
        end
    end

    fpu_lshift_stage #(.WIDTH(WIDTH), .STEP_LOG(3), .AMT_W(WIDTH_LOG-3)) u_shift_hi (
        .data_in  (in_mant),
        .amt      (shamt_c[WIDTH_LOG-1:3]),
        .data_out (mant_hi_c)
    );

    fpu_lshift_stage #(.WIDTH(WIDTH), .STEP_LOG(0), .AMT_W(3)) u_shift_lo (
        .data_in  (mant_p1),
        .amt      (shamt_lo_p1),
        .data_out (mant_lo_c)
    );

    // Stage 1: coarse shift, exponent adjust and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            mant_p1     <= '0;
            shamt_lo_p1 <= '0;
            exp_p1      <= '0;
            zero_p1     <= 1'b0;
            denorm_p1   <= 1'b0;
        end else if (en1) begin
            vld_p1      <= in_valid;
            mant_p1     <= mant_hi_c;
            shamt_lo_p1 <= shamt_c[2:0];
            exp_p1      <= exp_c;
            zero_p1     <= zero_c;
            denorm_p1   <= denorm_c;
        end
    end

    // Stage 2: fine shift into the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (en2) begin
            vld_p2     <= vld_p1;
            out_mant   <= mant_lo_c;
            out_exp    <= exp_p1;
            out_zero   <= zero_p1;
            out_denorm <= denorm_p1;
        end
    end

endmodule
